alu_operand_fetch: RTL and testbench

- Issue stage directly upstream of the ALU.
- Accepts 16-bit instruction words, decodes them, and reads two operands from an internal register file (with same-cycle writeback bypass).
- Blocks read-after-write hazards with a per-register scoreboard.
- Presents {alu_op, op1, op2, rd} to the ALU through a one-entry valid/ready output register. Results return on the writeback port after the downstream stage has registered the ALU output.

---
 rtl/alu_operand_fetch.sv | 138 +++++++++++++
 tb/tb_alu_operand_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_fetch.sv
// ============================================================================
//  Module   : alu_operand_fetch
//  Purpose  : Issue stage ahead of the ALU. It decodes the instruction word, reads
//             operands with writeback bypass, blocks RAW/WAW hazards and holds a
//             one-entry valid/ready bundle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_fetch #(
  parameter int WIDTH    = 15,
  parameter int OP_WIDTH = 3,
  parameter int AW       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [15:0]         instr,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [WIDTH-1:0]    wb_data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [OP_WIDTH-1:0] ex_alu_op,
  output logic [WIDTH-1:0]    ex_op1,
  output logic [WIDTH-1:0]    ex_op2,
  output logic [AW-1:0]       ex_rd
);

  localparam int DEPTH = 1 << AW;

  logic [OP_WIDTH-1:0] op;
  logic [AW-1:0]       rd;
  logic [AW-1:0]       rs1;
  logic [AW-1:0]       rs2;
  logic                imm_sel;
  logic [WIDTH-1:0]    imm;
  logic                unused_low;

  assign op         = instr[15:13];
  assign rd         = instr[12:10];
  assign rs1        = instr[9:7];
  assign imm_sel    = instr[6];
  assign rs2        = instr[5:3];
  assign imm        = {{(WIDTH-6){1'b0}}, instr[5:0]};
  assign unused_low = ^instr[2:0];

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;

  logic op_legal;
  logic wb_hit_rs1;
  logic wb_hit_rs2;
  logic hazard;
  logic accept;
  logic load;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;

  assign op_legal   = (op >= OP_WIDTH'(1)) && (op <= OP_WIDTH'(5));
  assign wb_hit_rs1 = wb_en && (wb_addr == rs1);
  assign wb_hit_rs2 = wb_en && (wb_addr == rs2);

  // pending[0] is never set, so r0 sources and r0 destinations never stall
  assign hazard = (pending[rs1] && !wb_hit_rs1)
               || (!imm_sel && pending[rs2] && !wb_hit_rs2)
               || ((rd != '0) && pending[rd]);

  assign instr_ready = !rst && !hazard && (!ex_valid || ex_ready);
  assign accept      = instr_valid && instr_ready;
  assign load        = accept && op_legal;

  always_comb begin
    rs1_val = regs[rs1];
    if (rs1 == '0)
      rs1_val = '0;
    else if (wb_hit_rs1)
      rs1_val = wb_data;
  end

  always_comb begin
    rs2_val = regs[rs2];
    if (imm_sel)
      rs2_val = imm;
    else if (rs2 == '0)
      rs2_val = '0;
    else if (wb_hit_rs2)
      rs2_val = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Set is applied after clear so a same-cycle set on the same register wins
  always_comb begin
    pending_nxt = pending;
    if (wb_en)
      pending_nxt[wb_addr] = 1'b0;
    if (load && (rd != '0))
      pending_nxt[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_alu_op <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      ex_rd     <= '0;
    end else if (load) begin
      ex_valid  <= 1'b1;
      ex_alu_op <= op;
      ex_op1    <= rs1_val;
      ex_op2    <= rs2_val;
      ex_rd     <= rd;
    end else if (ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: the expected bundle is queued at issue time and
// popped by a monitor whenever the DUT hands a bundle to the ALU stage.
`default_nettype none

module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [14:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_alu_op;
  logic [14:0] ex_op1;
  logic [14:0] ex_op2;
  logic [2:0]  ex_rd;

  alu_operand_fetch #(.WIDTH(15), .OP_WIDTH(3), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [35:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic isel,
                                     input logic [5:0] low);
    return {op, rd, rs1, isel, low};
  endfunction

  function automatic logic [35:0] bnd(input logic [2:0] op, input logic [14:0] a,
                                      input logic [14:0] b, input logic [2:0] rd);
    return {op, a, b, rd};
  endfunction

  // Monitor: a bundle is consumed whenever valid and ready meet
  always @(negedge clk) begin
    if (ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bundle", {ex_alu_op, ex_op1, ex_op2, ex_rd}, 36'h0);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("bundle", {ex_alu_op, ex_op1, ex_op2, ex_rd}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction until accepted (bounded); queue its bundle if legal
  task automatic issue(input string name, input logic [15:0] w, input bit legal,
                       input logic [35:0] e, input bit nostall);
    int n;
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, instr_ready, 1);
    if (nostall) chk({name, "_nostall"}, n, 0);
    if (instr_ready && legal) exp_q.push_back(e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_fields", {ex_alu_op, ex_op1, ex_op2, ex_rd}, 0);
    chk("rst_instr_ready", instr_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", instr_ready, 1);
    @(posedge clk); #1;

    // Load r1=5, r2=3
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 15'h0005; tick();
    wb_addr = 3'd2; wb_data = 15'h0003; tick();
    wb_en = 1'b0;

    issue("add_r3", mk(3'b001, 3'd3, 3'd1, 1'b0, {3'd2, 3'd0}), 1, bnd(3'b001, 15'd5, 15'd3, 3'd3), 1);

    // RAW on r3 stalls until its writeback, then bypasses
    instr = mk(3'b010, 3'd4, 3'd3, 1'b0, {3'd0, 3'd0});
    instr_valid = 1'b1;
    @(negedge clk);
    chk("add_valid_next", ex_valid, 1);
    chk("raw_stall0", instr_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("raw_stall1", instr_ready, 0);
    @(posedge clk); #1;
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 15'h0008;
    @(negedge clk);
    chk("raw_bypass_ready", instr_ready, 1);
    if (instr_ready) exp_q.push_back(bnd(3'b010, 15'd8, 15'd0, 3'd4));
    @(posedge clk); #1;
    wb_en = 1'b0; instr_valid = 1'b0;

    // Back-pressure: sub bundle held 4 cycles, next instruction waits
    ex_ready = 1'b0;
    instr = mk(3'b011, 3'd5, 3'd1, 1'b0, {3'd2, 3'd0});
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_ready", instr_ready, 0);
      chk("hold_bundle", {ex_valid, ex_alu_op, ex_op1, ex_op2, ex_rd},
          {1'b1, 3'b010, 15'd8, 15'd0, 3'd4});
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", instr_ready, 1);
    if (instr_ready) exp_q.push_back(bnd(3'b011, 15'd5, 15'd3, 3'd5));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("no_gap", {ex_valid, ex_rd}, {1'b1, 3'd5});
    @(posedge clk); #1;

    // Immediates: rs2 field (r4 pending) must not stall
    issue("xor_imm27", mk(3'b101, 3'd6, 3'd0, 1'b1, 6'h27), 1, bnd(3'b101, 15'd0, 15'h27, 3'd6), 1);
    issue("xor_imm3f", mk(3'b101, 3'd7, 3'd0, 1'b1, 6'h3F), 1, bnd(3'b101, 15'd0, 15'h3F, 3'd7), 1);

    // Illegal ops are consumed silently
    issue("op110", mk(3'b110, 3'd1, 3'd1, 1'b0, 6'h0), 0, '0, 1);
    issue("op000", mk(3'b000, 3'd1, 3'd1, 1'b0, 6'h0), 0, '0, 1);
    @(negedge clk);
    chk("illegal_no_valid", ex_valid, 0);
    @(posedge clk); #1;
    issue("add_r1_src", mk(3'b001, 3'd2, 3'd1, 1'b0, 6'h0), 1, bnd(3'b001, 15'd5, 15'd0, 3'd2), 1);

    // r0 ignores writes and bypass
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 15'h7FFF; tick();
    wb_data = 15'h1234;
    issue("or_r0", mk(3'b100, 3'd1, 3'd0, 1'b0, 6'h0), 1, bnd(3'b100, 15'd0, 15'd0, 3'd1), 1);
    wb_en = 1'b0;
    tick();

    // Reset while a bundle is held and registers are pending
    ex_ready = 1'b0;
    issue("or_r3", mk(3'b100, 3'd3, 3'd3, 1'b0, 6'h0), 1, bnd(3'b100, 15'd8, 15'd0, 3'd3), 1);
    rst = 1'b1; wb_en = 1'b1; wb_addr = 3'd1; wb_data = 15'h1111;
    @(negedge clk);
    chk("pre_rst_held", ex_valid, 1);
    chk("in_rst_ready", instr_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; wb_en = 1'b0; ex_ready = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    chk("post_rst_valid", ex_valid, 0);
    chk("post_rst_fields", {ex_alu_op, ex_op1, ex_op2, ex_rd}, 0);
    @(posedge clk); #1;
    issue("post_rst_pend", mk(3'b001, 3'd5, 3'd5, 1'b0, {3'd6, 3'd0}), 1, bnd(3'b001, 15'd0, 15'd0, 3'd5), 1);
    issue("post_rst_regs", mk(3'b100, 3'd2, 3'd1, 1'b0, {3'd3, 3'd0}), 1, bnd(3'b100, 15'd0, 15'd0, 3'd2), 1);

    for (int i = 0; i < 4; i++) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
